mult8_seq_ctrl: RTL and testbench
=================================

Name: mult8_seq_ctrl

Overview:
Sequencing controller that computes a 2N-bit × 2N-bit product by time-multiplexing one external N×N multiplier core, such as the team's 4×4 composite multipliers, across four partial products (ll, lh, hl, hh). It accepts operands over a valid/ready handshake and issues one half-operand pair to the shared core per cycle. It accumulates the shifted partial products and presents the 4N-bit result over a valid/ready handshake. It sits between a producer of operand pairs and a single instantiated N×N approximate core, allowing wider multiplications without replicating cores.

Parameters:
HALF, 4, core operand width N; operands are 2*HALF bits, core product 2*HALF bits, result 4*HALF bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
a  input  2*HALF  multiplicand
b  input  2*HALF  multiplier
core_a  output  HALF  operand A to shared core
core_b  output  HALF  operand B to shared core
core_p  input  2*HALF  combinational product returned by core
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
p  output  4*HALF  accumulated product
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: one clock, synchronous active-high. State goes to IDLE. a_q, b_q, acc, and step are cleared; out_valid=0, p=0, busy=0. in_ready is decoded from state, so it is 1 in the first cycle after rst deasserts.
- IDLE: in_ready=1. When in_valid&&in_ready: capture a_q=a, b_q=b, clear acc, set step=LL, go to CALC. in_valid alone in any other state is ignored; the operands are not captured.
- CALC: in_ready=0, busy=1. One step per cycle, in the order LL, LH, HL, HH.
  - Step LL: core_a=a_q[lo], core_b=b_q[lo], shift 0.
  - Step LH: core_a=a_q[lo], core_b=b_q[hi], shift HALF.
  - Step HL: core_a=a_q[hi], core_b=b_q[lo], shift HALF.
  - Step HH: core_a=a_q[hi], core_b=b_q[hi], shift 2*HALF.
  - Each cycle: acc <= acc + (core_p << shift), truncated mod 2^(4*HALF). This matters because an approximate core may return values above the exact maximum; the wrap is silent and carries no flag.
  - After HH: go to DONE.
- core_a and core_b are combinational from state, step, a_q and b_q. They are 0 outside CALC.
- DONE: out_valid=1 and p=acc, held stable until out_ready. On out_valid&&out_ready, go to IDLE and deassert out_valid the next cycle. There is no acceptance of new operands in the same cycle.
- Latency: operands accepted at edge T give out_valid high in the cycle after edge T+4 (4 CALC cycles). Throughput is at best one result per 6 cycles.
- p is registered and holds its last value in IDLE. It is cleared only by rst.
- rst asserted mid-CALC or in DONE aborts the operation; the pending result is discarded and not presented.

Optional Feature:
Macro MULT8_SEQ_SKIP_ZERO_EN.
- Defined:
  - In CALC, any step whose core_a or core_b half is zero is skipped and contributes 0 to acc; the core result is ignored even if nonzero.
  - The step pointer advances to the next step with both halves nonzero. If none remain, go to DONE.
  - If a==0 or b==0, IDLE goes directly to DONE with acc=0, so out_valid is high after edge T+1.
  - Latency is 1 plus the number of non-skipped steps, with a minimum of 1.
- Undefined: always exactly 4 CALC cycles. Zero halves are passed to the core and its product is accumulated.

Decomposition:
- Package mult_seq_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the step enum (LL, LH, HL, HH);
  - the HALF default;
  - a function returning the shift amount per step.
- No sub-module is required. The core is instantiated by the parent, and the step/operand mux stays inline.

Test Plan:
1. Bench core exact; a=8'd200, b=8'd150 -> out_valid 5 cycles after accept, p=16'd30000, core_a/core_b sequence (8,6),(8,9),(12,6),(12,9).
2. Exact core; a=b=8'hFF -> p=16'd65025. Hold out_ready=0 for 10 cycles -> p and out_valid stable, in_ready=0 throughout.
3. Bench core forced to return 8'hFF; a=b=8'hFF -> p=16'h1FDF (73695 mod 65536), no error indication.
4. Exact core; accept a=8'd17, b=8'd33, assert rst in 3rd CALC cycle -> next cycle state IDLE, out_valid=0, p=0, in_ready=1. A new op a=3, b=4 then yields p=12.
5. MULT8_SEQ_SKIP_ZERO_EN defined; a=8'h05, b=8'h03 -> only LL issued, out_valid 2 cycles after accept, p=15. a=0, b=8'h7F -> out_valid 1 cycle after accept, p=0, core inputs stay 0.
6. Back-to-back: in_valid held high with 3 operand pairs, out_ready=1 -> each accepted only in IDLE, results in order, 6-cycle spacing.

Source files
------------

// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared types for the sequenced wide multiplier controller: FSM states,
// partial-product step encoding, default half width and per-step shift.
package mult_seq_pkg;

    localparam int unsigned HALF_DEFAULT = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Encoding doubles as the issue order: LL, LH, HL, HH.
    typedef enum logic [1:0] {
        LL = 2'd0,
        LH = 2'd1,
        HL = 2'd2,
        HH = 2'd3
    } step_e;

    // Left shift applied to the core product of a given step.
    function automatic int unsigned step_shift(input step_e step, input int unsigned half);
        int unsigned sh;
        case (step)
            LL:      sh = 32'd0;
            LH:      sh = half;
            HL:      sh = half;
            HH:      sh = 32'd2 * half;
            default: sh = 32'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mult8_seq_ctrl.sv
// Sequencing controller: builds a 2N x 2N product from four N x N partial
// products computed one per cycle on a single shared external core.
// Optional build macro MULT8_SEQ_SKIP_ZERO_EN: steps whose half operands
// include a zero are not issued, and a zero operand finishes immediately.
module mult8_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned HALF = HALF_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF-1:0]   a,
    input  logic [2*HALF-1:0]   b,
    output logic [HALF-1:0]     core_a,
    output logic [HALF-1:0]     core_b,
    input  logic [2*HALF-1:0]   core_p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*HALF-1:0]   p,
    output logic                busy
);

    localparam int unsigned W  = 2 * HALF;
    localparam int unsigned PW = 4 * HALF;

    state_e          state_r;
    step_e           step_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [PW-1:0]   acc_r;
    logic [PW-1:0]   p_r;
    logic            out_valid_r;
    logic            busy_r;

    logic [3:0]      live_in_s;
    logic [3:0]      live_q_s;
    logic [2:0]      first_s;
    logic [2:0]      next_s;
    logic [PW-1:0]   term_s;
    logic [PW-1:0]   acc_next_s;

    // Per-step flag (bit index = step) that both half operands are nonzero.
    function automatic logic [3:0] live_steps(input logic [W-1:0] x, input logic [W-1:0] y);
        logic xl;
        logic xh;
        logic yl;
        logic yh;
        xl = |x[HALF-1:0];
        xh = |x[W-1:HALF];
        yl = |y[HALF-1:0];
        yh = |y[W-1:HALF];
        return {xh & yh, xh & yl, xl & yh, xl & yl};
    endfunction

    // Lowest live step at or above start; result is {found, step index}.
    function automatic logic [2:0] find_live(input logic [3:0] live, input logic [2:0] start);
        logic [2:0] hit;
        hit = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (live[i] && (3'(i) >= start)) begin
                hit = {1'b1, 2'(i)};
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign p         = p_r;
    assign busy      = busy_r;

    // Which steps get issued for the incoming and the captured operands.
    always_comb begin
`ifdef MULT8_SEQ_SKIP_ZERO_EN
        live_in_s = live_steps(a, b);
        live_q_s  = live_steps(a_r, b_r);
`else
        live_in_s = 4'b1111;
        live_q_s  = 4'b1111;
`endif
        first_s = find_live(live_in_s, 3'd0);
        next_s  = find_live(live_q_s, {1'b0, step_r} + 3'd1);
    end

    // Half-operand mux toward the shared core; idle at zero outside CALC.
    always_comb begin
        core_a = '0;
        core_b = '0;
        if (state_r == CALC) begin
            case (step_r)
                LL: begin core_a = a_r[HALF-1:0]; core_b = b_r[HALF-1:0]; end
                LH: begin core_a = a_r[HALF-1:0]; core_b = b_r[W-1:HALF]; end
                HL: begin core_a = a_r[W-1:HALF]; core_b = b_r[HALF-1:0]; end
                HH: begin core_a = a_r[W-1:HALF]; core_b = b_r[W-1:HALF]; end
                default: begin core_a = '0; core_b = '0; end
            endcase
        end else begin
            core_a = '0;
            core_b = '0;
        end
    end

    // Shifted partial product and wrapped accumulator sum for this step.
    always_comb begin
        term_s = PW'(core_p) << step_shift(step_r, HALF);
`ifdef MULT8_SEQ_SKIP_ZERO_EN
        if ((core_a == '0) || (core_b == '0)) begin
            term_s = '0;
        end else begin
            term_s = term_s;
        end
`endif
        acc_next_s = acc_r + term_s;
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            step_r      <= LL;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            p_r         <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        acc_r  <= '0;
                        busy_r <= 1'b1;
                        if (first_s[2]) begin
                            state_r <= CALC;
                            step_r  <= step_e'(first_s[1:0]);
                        end else begin
                            state_r     <= DONE;
                            step_r      <= LL;
                            p_r         <= '0;
                            out_valid_r <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    if (next_s[2]) begin
                        step_r <= step_e'(next_s[1:0]);
                    end else begin
                        state_r     <= DONE;
                        p_r         <= acc_next_s;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: table vectors, reset abort,
// randomized operations against an arithmetic model, back-to-back traffic.
module tb_mult8_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  core_a;
    logic [3:0]  core_b;
    logic [7:0]  core_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;
    logic        force_ff;

    int errors = 0;
    int checks = 0;

    mult8_seq_ctrl #(.HALF(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .core_a(core_a), .core_b(core_b), .core_p(core_p),
        .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    // Behavioural shared core: exact 4x4 product or a stuck-at-FF result.
    assign core_p = force_ff ? 8'hFF : ({4'd0, core_a} * {4'd0, core_b});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: expected product, number of issued steps and issued pairs.
    task automatic model(input logic [7:0] x, input logic [7:0] y, input bit f,
                         output logic [15:0] ep, output int n, output logic [31:0] pairs);
        int unsigned sum;
        int unsigned ha;
        int unsigned hb;
        int unsigned sh;
        bit live;
        sum = 0;
        n = 0;
        pairs = 32'd0;
        for (int s = 0; s < 4; s++) begin
            ha = (s >= 2) ? x / 16 : x % 16;
            hb = (s % 2 == 1) ? y / 16 : y % 16;
            sh = (s == 0) ? 0 : ((s == 3) ? 8 : 4);
            live = 1'b1;
`ifdef MULT8_SEQ_SKIP_ZERO_EN
            live = (ha != 0) && (hb != 0);
`endif
            if (live) begin
                pairs[n*8 +: 8] = {ha[3:0], hb[3:0]};
                n++;
                sum += (f ? 255 : ha * hb) << sh;
            end
        end
        ep = f ? sum[15:0] : 16'(int'(x) * int'(y));
    endtask

    // One complete operation: accept, per-cycle core pairs, result, hold, drain.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input bit f,
                          input int hold, input logic [15:0] exp_p, input string tag);
        logic [15:0] ep;
        int n;
        logic [31:0] pairs;
        model(ta, tb_v, f, ep, n, pairs);
        @(negedge clk);
        force_ff = f;
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            check({tag, " out_valid during calc"}, 32'(out_valid), 32'd0);
            check({tag, " core pair"}, 32'({core_a, core_b}), 32'(pairs[k*8 +: 8]));
            if (k == 0) check({tag, " busy in calc"}, 32'(busy), 32'd1);
            @(negedge clk);
        end
        check({tag, " out_valid at latency"}, 32'(out_valid), 32'd1);
        check({tag, " p"}, 32'(p), 32'(exp_p));
        check({tag, " in_ready in done"}, 32'(in_ready), 32'd0);
        check({tag, " busy in done"}, 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold p"}, 32'(p), 32'(exp_p));
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid after drain"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after drain"}, 32'(in_ready), 32'd1);
        check({tag, " p held in idle"}, 32'(p), 32'(exp_p));
        check({tag, " core idle"}, 32'({core_a, core_b}), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        bit          f;
        int          hold;
        logic [15:0] ep;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] ep;
        int n;
        logic [31:0] pairs;
        logic [7:0] ra;
        logic [7:0] rb;
        bit rf;
        logic [7:0] qa[3];
        logic [7:0] qb[3];
        logic [15:0] qp[3];
        int qlat[3];
        int acc_cyc[3];
        int acc_idx;
        int res_idx;
        int last_out;

        vecs[0] = '{8'd200, 8'd150, 1'b0, 0,  16'd30000};
        vecs[1] = '{8'hFF,  8'hFF,  1'b0, 10, 16'd65025};
        vecs[2] = '{8'hFF,  8'hFF,  1'b1, 0,  16'h1FDF};
        vecs[3] = '{8'd3,   8'd4,   1'b0, 0,  16'd12};
        vecs[4] = '{8'h05,  8'h03,  1'b0, 0,  16'd15};
        vecs[5] = '{8'h00,  8'h7F,  1'b0, 2,  16'd0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        force_ff = 1'b0;
        a = 8'd0;
        b = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset p", 32'(p), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset core", 32'({core_a, core_b}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].f, vecs[i].hold, vecs[i].ep,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 5 == 0) ra[3:0] = 4'd0;
            rf = ($urandom_range(0, 3) == 0);
            model(ra, rb, rf, ep, n, pairs);
            run_op(ra, rb, rf, int'($urandom_range(0, 2)), ep, $sformatf("rand%0d", i));
        end

        // Abort in the third calculation cycle, then a fresh operation.
        @(negedge clk);
        force_ff = 1'b0;
        a = 8'd17;
        b = 8'd33;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort p", 32'(p), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort core", 32'({core_a, core_b}), 32'd0);
        run_op(8'd3, 8'd4, 1'b0, 0, 16'd12, "after abort");

        // Back-to-back: in_valid held high, out_ready held high.
        for (int i = 0; i < 3; i++) begin
            qa[i] = 8'($urandom_range(1, 255));
            qb[i] = 8'($urandom_range(1, 255));
            model(qa[i], qb[i], 1'b0, qp[i], n, pairs);
            qlat[i] = n + 1;
        end
        acc_idx = 0;
        res_idx = 0;
        last_out = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && res_idx < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("b2b p", 32'(p), 32'(qp[res_idx]));
                check("b2b latency", 32'(c - acc_cyc[res_idx]), 32'(qlat[res_idx]));
                check("b2b in_ready in done", 32'(in_ready), 32'd0);
`ifndef MULT8_SEQ_SKIP_ZERO_EN
                if (last_out >= 0) check("b2b spacing", 32'(c - last_out), 32'd6);
`endif
                last_out = c;
                res_idx++;
            end
            if (acc_idx < 3) begin
                a = qa[acc_idx];
                b = qb[acc_idx];
                in_valid = 1'b1;
                if (in_ready) begin
                    acc_cyc[acc_idx] = c;
                    acc_idx++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b results delivered", 32'(res_idx), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
